spe_dispatcher: RTL
===================

// Module: spe_dispatcher
// PURPOSE
// - Controller-side endpoint of the SPE packet link: builds 32-bit packets from commands and sends them to SPEs.
// - Accepts the SPE result packets coming back, checks them, unpacks them and hands them to the controller.
// - Limits in-flight requests with a credit counter.
// - Clocked, valid/ready on every port; sits between the controller FSM and the NoC router port.
// PARAMETERS
// - MY_ADDR     4'd0  this node's NoC address; result packets must carry dest == MY_ADDR
// - CMD_DEPTH   4     command FIFO entries, power of 2, >= 2
// - MAX_OUTST   8     max requests sent without a result, 1..15
// PORTS
// - clk          in   1   clock
// - rst          in   1   synchronous active-high reset
// - cmd_valid    in   1   command offered
// - cmd_ready    out  1   FIFO not full
// - cmd_dest     in   4   target SPE address
// - cmd_opcode   in   4   opcode
// - cmd_data     in   24  payload
// - tx_valid     out  1   packet to router valid
// - tx_ready     in   1   router accepts
// - tx_pkt       out  32  {dest[31:28], opcode[27:24], data[23:0]}
// - rx_valid     in   1   result packet from router valid
// - rx_ready     out  1   dispatcher accepts
// - rx_pkt       in   32  same format as tx_pkt
// - rsp_valid    out  1   unpacked result valid
// - rsp_ready    in   1   controller accepts
// - rsp_opcode   out  4   result opcode
// - rsp_data     out  24  result payload
// - outst_cnt    out  4   requests in flight
// - err_misroute out  1   1-cycle pulse: result dropped, dest != MY_ADDR
// - err_unexp    out  1   1-cycle pulse: valid result arrived with outst_cnt == 0 (still delivered)
// BEHAVIOUR
// - Reset: FIFO empty, cmd_ready=1, tx_valid=0, tx_pkt=0, rx_ready=1, rsp_valid=0, rsp_opcode/data=0, outst_cnt=0, errs=0.
// - Reset takes effect mid-transfer too. Any held packet or result is discarded; no handshake completes in the reset cycle.
// - Transfer rule: a transfer happens on a clk edge with valid&&ready.
// - Valid rule: once valid is raised, valid and payload stay stable until the transfer.
// - Command FIFO:
//   - Write on cmd_valid&&cmd_ready; cmd_ready = !full.
//   - Simultaneous push and pop when full is not allowed (cmd_ready=0). When empty, a push is visible next cycle (no bypass).
//   - Pointers wrap modulo CMD_DEPTH; an extra wrap bit distinguishes full from empty.
// - TX FSM:
//   - IDLE -> LOAD when FIFO not empty and outst_cnt < MAX_OUTST. LOAD pops the head into the tx_pkt register and sets tx_valid=1.
//   - LOAD -> SEND. SEND holds until tx_ready.
//   - On transfer: outst_cnt++. Return to IDLE, or go to LOAD if a command and a credit remain (gives 1 pkt / 2 cycles).
//   - IDLE -> STALL when FIFO not empty and outst_cnt == MAX_OUTST. STALL -> IDLE when a credit returns.
// - RX path:
//   - rx_ready = !rsp_valid || rsp_ready, i.e. a 1-entry output register that can drain and refill in the same cycle.
//   - On accept with dest == MY_ADDR: load rsp_*, set rsp_valid, outst_cnt-- (saturates at 0).
//   - On accept with dest != MY_ADDR: drop, pulse err_misroute, no credit change.
//   - err_unexp pulses when outst_cnt == 0 at the accept.
// - Same-cycle TX transfer and valid RX accept: outst_cnt is unchanged (net 0).
// - Latency: cmd accept to tx_valid = 3 cycles min. rx accept to rsp_valid = 1 cycle.
// STRUCTURE
// - Shared package spe_pkt_pkg:
//   - PKT_W=32, ADDR_W=4, OP_W=4, DATA_W=24
//   - typedef struct packed {dest, opcode, data} spe_pkt_t
//   - opcode localparams
//   - functions pack_pkt and unpack_pkt
// - Sub-module: spe_cmd_fifo (parameterised sync FIFO, width ADDR_W+OP_W+DATA_W).
// - TX FSM, credit counter and RX register live in the top.
// TESTING
// - Reset then one cmd (dest=3, op=2, data=24'h00ABCD), tx_ready=1 -> tx_pkt=32'h3200ABCD, outst_cnt=1.
// - 5 cmds with tx_ready=0 -> cmd_ready=0 after 4 stored. tx_pkt is stable across 10 stalled cycles. Raise tx_ready -> 5 packets sent in order.
// - MAX_OUTST=2, 3 cmds, no results -> 2 sent, FSM in STALL. Send rx_pkt=32'h0500_0001 -> 3rd packet sent, rsp_data=24'h000001.
// - rx_pkt dest=4'h7 -> err_misroute pulse, rsp_valid stays 0, outst_cnt unchanged. Result with outst_cnt=0 -> err_unexp pulse, rsp delivered.
// - rsp_ready=0 with a result held -> rx_ready=0. Next rx is accepted in the same cycle rsp_ready=1 (back-to-back, no bubble).
// - rst asserted while in SEND with FIFO holding 2 -> next cycle tx_valid=0, cmd_ready=1, outst_cnt=0, FIFO empty.

Source files
------------

// File: rtl/spe_pkt_pkg.sv
// Shared SPE link packet format: field widths, packet struct, opcodes and pack/unpack helpers.
// Packet layout on the wire is {dest, opcode, data}, MSB first.
package spe_pkt_pkg;

  localparam int PKT_W  = 32;
  localparam int ADDR_W = 4;
  localparam int OP_W   = 4;
  localparam int DATA_W = 24;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] data;
  } spe_pkt_t;

  localparam logic [OP_W-1:0] OP_NOP    = 4'h0;
  localparam logic [OP_W-1:0] OP_LOAD   = 4'h1;
  localparam logic [OP_W-1:0] OP_EXEC   = 4'h2;
  localparam logic [OP_W-1:0] OP_STORE  = 4'h3;
  localparam logic [OP_W-1:0] OP_RESULT = 4'h5;

  function automatic spe_pkt_t pack_pkt(input logic [ADDR_W-1:0] dest,
                                        input logic [OP_W-1:0]   opcode,
                                        input logic [DATA_W-1:0] data);
    spe_pkt_t p;
    p.dest   = dest;
    p.opcode = opcode;
    p.data   = data;
    return p;
  endfunction

  function automatic spe_pkt_t unpack_pkt(input logic [PKT_W-1:0] raw);
    return spe_pkt_t'(raw);
  endfunction

endpackage

// File: rtl/spe_cmd_fifo.sv
// Synchronous command FIFO, registered head, no write-to-read bypass (push visible next cycle).
// Backpressure: full blocks push; pop on empty is ignored.
module spe_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer tells a full ring from an empty one.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spe_dispatcher.sv
// Controller-side SPE link endpoint: command FIFO -> credit-limited TX FSM; RX results -> 1-entry rsp register.
// Latency: cmd accept to tx_valid 3 cycles, rx accept to rsp_valid 1 cycle; rx_ready = !rsp_valid || rsp_ready.
module spe_dispatcher
  import spe_pkt_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MY_ADDR   = 4'd0,
  parameter int                CMD_DEPTH = 4,
  parameter int                MAX_OUTST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_dest,
  input  logic [OP_W-1:0]   cmd_opcode,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [PKT_W-1:0]  tx_pkt,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [PKT_W-1:0]  rx_pkt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OP_W-1:0]   rsp_opcode,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        outst_cnt,
  output logic              err_misroute,
  output logic              err_unexp
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_STALL} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

  state_t   state, state_nxt;
  spe_pkt_t cmd_pkt, fifo_head, rx_p;
  logic     fifo_full, fifo_empty, fifo_pop;
  logic     tx_fire, rx_fire, rx_good, credit_ret;
  logic [3:0] cnt_nxt;

  assign cmd_pkt   = pack_pkt(cmd_dest, cmd_opcode, cmd_data);
  assign cmd_ready = !fifo_full;

  spe_cmd_fifo #(.WIDTH(PKT_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data (cmd_pkt),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

  assign rx_p       = unpack_pkt(rx_pkt);
  assign rx_ready   = !rsp_valid || rsp_ready;
  assign tx_fire    = tx_valid && tx_ready;
  assign rx_fire    = rx_valid && rx_ready;
  assign rx_good    = rx_fire && (rx_p.dest == MY_ADDR);
  assign credit_ret = rx_good && (outst_cnt != 4'd0);

  // A send and a good result in the same cycle cancel out, even at zero.
  always_comb begin
    cnt_nxt = outst_cnt;
    if (tx_fire && !rx_good)       cnt_nxt = outst_cnt + 4'd1;
    else if (!tx_fire && credit_ret) cnt_nxt = outst_cnt - 4'd1;
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nxt = (cnt_nxt < MAX_CNT) ? S_LOAD : S_STALL;
      S_LOAD: begin
        fifo_pop  = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND:  if (tx_fire) state_nxt = (!fifo_empty && cnt_nxt < MAX_CNT) ? S_LOAD : S_IDLE;
      S_STALL: if (credit_ret) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tx_valid  <= 1'b0;
      tx_pkt    <= '0;
      outst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      outst_cnt <= cnt_nxt;
      if (fifo_pop) begin
        tx_valid <= 1'b1;
        tx_pkt   <= fifo_head;
      end else if (tx_fire) begin
        tx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_opcode   <= '0;
      rsp_data     <= '0;
      err_misroute <= 1'b0;
      err_unexp    <= 1'b0;
    end else begin
      err_misroute <= rx_fire && (rx_p.dest != MY_ADDR);
      err_unexp    <= rx_good && (outst_cnt == 4'd0);
      if (rx_good) begin
        rsp_valid  <= 1'b1;
        rsp_opcode <= rx_p.opcode;
        rsp_data   <= rx_p.data;
      end else if (rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

endmodule
